// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared FSM state encoding, port indices and default memory size for dmem_arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  localparam int DEF_MEM_BYTES = 32;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester bus (req/we/addr/wdata per port in; gnt/rvalid/rdata/err out); master = requesters, slave = arbiter
interface dmem_arbiter_if;
  logic [1:0] req_i;
  logic [1:0] we_i;
  logic [31:0] addr0_i;
  logic [31:0] addr1_i;
  logic [31:0] wdata0_i;
  logic [31:0] wdata1_i;
  logic [1:0] gnt_o;
  logic [1:0] rvalid_o;
  logic [31:0] rdata_o;
  logic err_o;
  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    input gnt_o, rvalid_o, rdata_o, err_o
  );
  modport slave (
    input req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way combinational arbiter; req_i, last_i (last served port), fixed_i (port 0 priority) -> one-hot gnt_o
module rr_arb2 (
  input logic [1:0] req_i,
  input logic last_i,
  input logic fixed_i,
  output logic [1:0] gnt_o
);
  assign gnt_o = &req_i ? ((fixed_i || last_i) ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the byte-addressed data memory; clk_i/rst_i, bus (requester slave modport), mem_* memory side
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic clk_i,
  input logic rst_i,
  dmem_arbiter_if.slave bus,
  output logic mem_write_o,
  output logic mem_read_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input logic [31:0] mem_data_i
);
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);
  state_t state;
  logic owner;
  logic last;
  logic we_q;
  logic err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0] rvalid_q;
  logic [1:0] win;
  logic in_range;
  logic access;
  rr_arb2 u_arb (
    .req_i(bus.req_i),
    .last_i(last),
    .fixed_i(FIXED_PRIO),
    .gnt_o(win)
  );
  assign in_range = addr_q <= LAST_ADDR;
  assign access = state == ACCESS && in_range && !rst_i;
  assign bus.gnt_o = (state == IDLE && !rst_i) ? win : 2'b00;
  assign bus.rvalid_o = rst_i ? 2'b00 : rvalid_q;
  assign bus.rdata_o = rdata_q;
  assign bus.err_o = err_q;
  assign mem_write_o = access && we_q;
  assign mem_read_o = access && !we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= PORT_CPU;
      last <= PORT_AUX;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= 2'b00;
      case (state)
        IDLE: if (|bus.req_i) begin
          owner <= win[1];
          last <= win[1];
          we_q <= bus.we_i[win[1]];
          addr_q <= win[1] ? bus.addr1_i : bus.addr0_i;
          wdata_q <= win[1] ? bus.wdata1_i : bus.wdata0_i;
          state <= ACCESS;
        end
        ACCESS: begin
          rdata_q <= (in_range && !we_q) ? mem_data_i : '0;
          err_q <= !in_range;
          rvalid_q <= owner ? 2'b10 : 2'b01;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the byte-addressed, 32-byte data memory.
- Port 0 is the CPU MEM stage; port 1 is an auxiliary requester (test loader / DMA).
- Grants one 32-bit little-endian access at a time and drives the memory's write-enable, read-enable, address and write-data inputs.
- Returns a registered read response and rejects out-of-range addresses with an error flag, without touching memory.

Parameters:
- MEM_BYTES, 32, memory size in bytes; the last legal word address is MEM_BYTES-4.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
- clk_i  in  1  clock; memory writes occur on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  2  per-port request; held with its fields until that port's gnt_o.
- we_i  in  2  per-port write (1) / read (0).
- addr0_i, addr1_i  in  32 each  byte address per port.
- wdata0_i, wdata1_i  in  32 each  write data per port.
- gnt_o  out  2  one-hot accept pulse (combinational, IDLE only).
- rvalid_o  out  2  one-hot completion pulse, one cycle wide.
- rdata_o  out  32  read data, valid with rvalid_o.
- err_o  out  1  out-of-range flag, valid with rvalid_o.
- mem_write_o  out  1  to memory MemWrite.
- mem_read_o  out  1  to memory MemRead.
- mem_addr_o  out  32  to memory addr.
- mem_data_o  out  32  to memory write data.
- mem_data_i  in  32  from memory read data (combinational read).

Behaviour:
- Reset, synchronous on rst_i high:
  - State becomes IDLE; owner, latched fields, rdata_o and err_o are cleared.
  - Round-robin pointer is set so that port 0 wins first.
  - gnt_o, rvalid_o, mem_write_o and mem_read_o are 0.
- State machine IDLE -> ACCESS -> RESP -> IDLE; each state lasts exactly one cycle.
- IDLE:
  - If any req_i bit is set, assert gnt_o for the winner in the same cycle.
  - Latch owner, we, addr and wdata from the winner; next state is ACCESS. Otherwise stay in IDLE.
- Arbitration:
  - When only one port requests, that port wins.
  - When both request and FIXED_PRIO=1, port 0 wins.
  - When both request and FIXED_PRIO=0, the port not served last wins; the pointer updates on every grant.
- ACCESS:
  - mem_addr_o and mem_data_o carry the latched addr and wdata.
  - If the latched addr is in range (addr <= MEM_BYTES-4, unsigned 32-bit compare, no wrap):
    - Write: mem_write_o=1; the memory commits on the edge ending this cycle.
    - Read: mem_read_o=1; mem_data_i is registered into rdata_o at the end of the cycle.
  - If out of range: both enables stay 0, err is set, and rdata is set to 0.
- RESP: rvalid_o[owner]=1; rdata_o and err_o are held. Writes return rdata_o=0. Next state is IDLE.
- Enable gating: mem_write_o and mem_read_o are only ever high in ACCESS.
- Timing:
  - Fixed latency: grant in cycle N, memory op in N+1, rvalid_o in N+2.
  - Throughput is one access per 3 cycles; next grant earliest N+3.
- Requests during ACCESS/RESP are ignored (no grant); requesters keep req_i high.
- Reset mid-operation:
  - mem_write_o is gated with !rst_i, so rst_i high during ACCESS prevents the write.
  - Any pending response is dropped and no rvalid_o is issued.
- Holding req_i high while in RESP does not extend or repeat the response.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding (IDLE, ACCESS, RESP)
  - port indices (PORT_CPU=0, PORT_AUX=1)
  - default MEM_BYTES
- Sub-module rr_arb2, combinational:
  - inputs: 2-bit request, last-served pointer, FIXED_PRIO
  - output: one-hot winner
- The FSM, latches and pointer register stay in dmem_arbiter.

Test Plan:
- Reset then idle -> all outputs 0 for 5 cycles; no memory enables.
- Port 0 write addr=8, wdata=0xDEADBEEF, then port 0 read addr=8 -> gnt_o=01 at N; mem_write_o=1 at N+1; rvalid_o=01 at N+2 with err_o=0. The later read returns rdata_o=0xDEADBEEF. A read at addr=9 returns 0x00DEADBE in its low 24 bits (little-endian byte check).
- Both ports request reads every cycle, FIXED_PRIO=0 -> grants alternate 01,10,01,10 every 3 cycles. With FIXED_PRIO=1 -> only 01 is granted while port 0 keeps requesting.
- Port 1 write addr=29 (>28) and addr=0xFFFFFFFE -> mem_write_o stays 0; rvalid_o=10 with err_o=1 and rdata_o=0; memory bytes 28..31 are unchanged.
- rst_i pulsed during ACCESS of a write to addr=4 data=0x12345678 -> no mem_write_o; a later read of addr=4 returns the prior contents; no rvalid_o issued.
- Port 1 requests during port 0's ACCESS -> gnt_o=10 exactly at the next IDLE cycle (N+3), not earlier.
